// File: rtl/td4_pkg.sv
// Shared definitions for the td4_core 4-bit CPU: word widths, opcodes,
// architectural state layout and debug register indices.
package td4_pkg;

    localparam int DATA_W = 4;
    localparam int INSN_W = 8;
    localparam int DBG_N  = 8;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [2:0]        dbg_idx_t;

    typedef enum logic [3:0] {
        OP_ADD_A    = 4'b0000,
        OP_MOV_A_B  = 4'b0001,
        OP_IN_A     = 4'b0010,
        OP_MOV_A_IM = 4'b0011,
        OP_MOV_B_A  = 4'b0100,
        OP_ADD_B    = 4'b0101,
        OP_IN_B     = 4'b0110,
        OP_MOV_B_IM = 4'b0111,
        OP_OUT_B    = 4'b1001,
        OP_OUT_IM   = 4'b1011,
        OP_JNC      = 4'b1110,
        OP_JMP      = 4'b1111
    } opcode_e;

    typedef struct packed {
        logic [3:0] opcode;
        word_t      im;
    } insn_t;

    // Architectural state, kept in one register so it can be observed as a unit.
    typedef struct packed {
        word_t a;
        word_t b;
        word_t out;
        word_t pc;
        logic  c;
    } arch_state_t;

    localparam dbg_idx_t DBG_A   = 3'd0;
    localparam dbg_idx_t DBG_B   = 3'd1;
    localparam dbg_idx_t DBG_C   = 3'd2;
    localparam dbg_idx_t DBG_BTN = 3'd3;
    localparam dbg_idx_t DBG_PC  = 3'd4;
    localparam dbg_idx_t DBG_R5  = 3'd5;
    localparam dbg_idx_t DBG_OUT = 3'd6;
    localparam dbg_idx_t DBG_R7  = 3'd7;

    function automatic logic is_add(input logic [3:0] opcode);
        return (opcode == OP_ADD_A) || (opcode == OP_ADD_B);
    endfunction

endpackage

// File: rtl/td4_alu.sv
// 4-bit adder: operand + im with carry-out. Used for both ADD forms and PC+1.
module td4_alu
    import td4_pkg::*;
(
    input  logic [DATA_W-1:0] operand,
    input  logic [DATA_W-1:0] im,
    output logic [DATA_W-1:0] sum,
    output logic              carry
);

    logic [DATA_W:0] full;

    always_comb begin
        full  = {1'b0, operand} + {1'b0, im};
        sum   = full[DATA_W-1:0];
        carry = full[DATA_W];
    end

endmodule

// File: rtl/td4_core.sv
// TD4-style single-cycle 4-bit CPU. Define DEBUG_REGS_EN to add the
// debug_regs port exposing A, B, C, btn, PC and OUT combinationally.
module td4_core
    import td4_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_PC = 4'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] btn,
    output logic [DATA_W-1:0] led,
    output logic [DATA_W-1:0] adr,
    input  logic [INSN_W-1:0] dout
`ifdef DEBUG_REGS_EN
    ,
    output logic [DATA_W-1:0] debug_regs [7:0]
`endif
);

    arch_state_t state_q;
    arch_state_t state_d;
    insn_t       insn;

    word_t alu_operand;
    word_t alu_sum;
    logic  alu_carry;
    word_t pc_inc;
    logic  pc_carry_unused;

    assign insn = insn_t'(dout);

    assign alu_operand = (insn.opcode == OP_ADD_B) ? state_q.b : state_q.a;

    td4_alu u_alu_data (
        .operand (alu_operand),
        .im      (insn.im),
        .sum     (alu_sum),
        .carry   (alu_carry)
    );

    // PC+1 reuses the adder; the 4-bit sum wraps F -> 0 naturally.
    td4_alu u_alu_pc (
        .operand (state_q.pc),
        .im      (4'h1),
        .sum     (pc_inc),
        .carry   (pc_carry_unused)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q.a   <= '0;
            state_q.b   <= '0;
            state_q.out <= '0;
            state_q.pc  <= RESET_PC;
            state_q.c   <= 1'b0;
        end else begin
            state_q <= state_d;
        end
    end

    // Every instruction rewrites C; only ADD can leave it set.
    always_comb begin
        state_d    = state_q;
        state_d.pc = pc_inc;
        state_d.c  = 1'b0;
        case (insn.opcode)
            OP_ADD_A: begin
                state_d.a = alu_sum;
                state_d.c = alu_carry;
            end
            OP_ADD_B: begin
                state_d.b = alu_sum;
                state_d.c = alu_carry;
            end
            OP_MOV_A_IM: state_d.a   = insn.im;
            OP_MOV_B_IM: state_d.b   = insn.im;
            OP_MOV_A_B:  state_d.a   = state_q.b;
            OP_MOV_B_A:  state_d.b   = state_q.a;
            OP_IN_A:     state_d.a   = btn;
            OP_IN_B:     state_d.b   = btn;
            OP_OUT_B:    state_d.out = state_q.b;
            OP_OUT_IM:   state_d.out = insn.im;
            OP_JMP:      state_d.pc  = insn.im;
            OP_JNC: begin
                if (!state_q.c) begin
                    state_d.pc = insn.im;
                end
            end
            default: ;
        endcase
    end

    assign led = state_q.out;
    assign adr = state_q.pc;

`ifdef DEBUG_REGS_EN
    always_comb begin
        debug_regs          = '{default: '0};
        debug_regs[DBG_A]   = state_q.a;
        debug_regs[DBG_B]   = state_q.b;
        debug_regs[DBG_C]   = {3'b000, state_q.c};
        debug_regs[DBG_BTN] = btn;
        debug_regs[DBG_PC]  = state_q.pc;
        debug_regs[DBG_R5]  = 4'h0;
        debug_regs[DBG_OUT] = state_q.out;
        debug_regs[DBG_R7]  = 4'h0;
    end
`endif

endmodule

// File: tb/tb_td4_core.sv
// Self-checking bench for td4_core: vector table with a {adr,led} scoreboard,
// plus a memory-driven counting program with a mid-run reset.
module tb_td4_core;
    import td4_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic [3:0] led;
    logic [3:0] adr;
    logic [7:0] dout;
    logic [7:0] dout_drv;
    logic       use_mem;
    logic [7:0] mem [16];
`ifdef DEBUG_REGS_EN
    logic [3:0] debug_regs [7:0];
`endif

    typedef struct {
        logic [7:0] insn;
        logic [3:0] btn;
        logic       btn_dc;
        logic [3:0] exp_adr;
        logic [3:0] exp_led;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    int         tests_run    = 0;
    int         tests_failed = 0;

    td4_core #(.RESET_PC(4'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .led   (led),
        .adr   (adr),
        .dout  (dout)
`ifdef DEBUG_REGS_EN
        ,
        .debug_regs (debug_regs)
`endif
    );

    // External program memory: asynchronous read, or direct drive from the table.
    assign dout = use_mem ? mem[adr] : dout_drv;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic compare_out(input string name);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: scoreboard empty, got %h", name, {adr, led});
        end else begin
            e = exp_q.pop_front();
            check(name, {adr, led}, e);
        end
    endtask

    task automatic step(input string name, input logic [3:0] e_adr, input logic [3:0] e_led);
        exp_q.push_back({e_adr, e_led});
        @(posedge clk);
        #1;
        compare_out(name);
    endtask

    task automatic drive(input string name, input logic [7:0] insn, input logic [3:0] b,
                         input logic [3:0] e_adr, input logic [3:0] e_led);
        dout_drv = insn;
        btn      = b;
        step(name, e_adr, e_led);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dout_drv = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic add_vec(input logic [7:0] insn, input logic [3:0] b, input logic dc,
                           input logic [3:0] e_adr, input logic [3:0] e_led);
        vec_t v;
        v.insn    = insn;
        v.btn     = b;
        v.btn_dc  = dc;
        v.exp_adr = e_adr;
        v.exp_led = e_led;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0] b;
        logic [3:0] exp_led;
        logic [3:0] cnt_adr [11];
        logic [3:0] cnt_led [11];

        reset    = 1'b1;
        btn      = 4'h0;
        dout_drv = 8'h00;
        use_mem  = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        // insn, btn, btn don't-care, expected adr, expected led after the edge
        add_vec(8'h33, 4'h0, 1'b1, 4'h1, 4'h0);
        add_vec(8'h0F, 4'h0, 1'b1, 4'h2, 4'h0);
        add_vec(8'hE0, 4'h0, 1'b1, 4'h3, 4'h0);
        add_vec(8'h40, 4'h0, 1'b1, 4'h4, 4'h0);
        add_vec(8'h90, 4'h0, 1'b1, 4'h5, 4'h2);
        add_vec(8'h0F, 4'h0, 1'b1, 4'h6, 4'h2);
        add_vec(8'h01, 4'h0, 1'b1, 4'h7, 4'h2);
        add_vec(8'hE9, 4'h0, 1'b1, 4'h9, 4'h2);
        add_vec(8'hB5, 4'h0, 1'b1, 4'hA, 4'h5);
        add_vec(8'h73, 4'h0, 1'b1, 4'hB, 4'h5);
        add_vec(8'h90, 4'h0, 1'b1, 4'hC, 4'h3);
        add_vec(8'hFA, 4'h0, 1'b1, 4'hA, 4'h3);
        add_vec(8'h3E, 4'h0, 1'b1, 4'hB, 4'h3);
        add_vec(8'hFF, 4'h0, 1'b1, 4'hF, 4'h3);
        add_vec(8'h5D, 4'h0, 1'b1, 4'h0, 4'h3);
        add_vec(8'hE7, 4'h0, 1'b1, 4'h1, 4'h3);
        add_vec(8'hE7, 4'h0, 1'b1, 4'h7, 4'h3);
        add_vec(8'h90, 4'h0, 1'b1, 4'h8, 4'h0);
        add_vec(8'h20, 4'hA, 1'b0, 4'h9, 4'h0);
        add_vec(8'h40, 4'hA, 1'b0, 4'hA, 4'h0);
        add_vec(8'h90, 4'hA, 1'b0, 4'hB, 4'hA);
        add_vec(8'h00, 4'h5, 1'b0, 4'hC, 4'hA);
        add_vec(8'h40, 4'h5, 1'b0, 4'hD, 4'hA);
        add_vec(8'h90, 4'h5, 1'b0, 4'hE, 4'hA);
        add_vec(8'h60, 4'h5, 1'b0, 4'hF, 4'hA);
        add_vec(8'h90, 4'h0, 1'b1, 4'h0, 4'h5);
        add_vec(8'hC3, 4'h0, 1'b1, 4'h1, 4'h5);
        add_vec(8'h8F, 4'h0, 1'b1, 4'h2, 4'h5);
        add_vec(8'h0F, 4'h0, 1'b1, 4'h3, 4'h5);
        add_vec(8'hC0, 4'h0, 1'b1, 4'h4, 4'h5);
        add_vec(8'hE5, 4'h0, 1'b1, 4'h5, 4'h5);
        add_vec(8'h0F, 4'h0, 1'b1, 4'h6, 4'h5);
        add_vec(8'hF9, 4'h0, 1'b1, 4'h9, 4'h5);
        add_vec(8'hE2, 4'h0, 1'b1, 4'h2, 4'h5);

        // Reset state
        reset_dut();
        exp_q.push_back({4'h0, 4'h0});
        compare_out("reset_adr_led");
`ifdef DEBUG_REGS_EN
        check("reset_dbg_a",   {4'h0, debug_regs[0]}, 8'h00);
        check("reset_dbg_b",   {4'h0, debug_regs[1]}, 8'h00);
        check("reset_dbg_c",   {4'h0, debug_regs[2]}, 8'h00);
        check("reset_dbg_out", {4'h0, debug_regs[6]}, 8'h00);
`endif

        // Vector table
        foreach (vecs[i]) begin
            b = vecs[i].btn_dc ? 4'($urandom_range(0, 15)) : vecs[i].btn;
            drive($sformatf("vec%0d_%h", i, vecs[i].insn), vecs[i].insn, b,
                  vecs[i].exp_adr, vecs[i].exp_led);
        end

        // Random switch values through IN A / MOV B,A / OUT B
        reset_dut();
        exp_led = 4'h0;
        for (int k = 0; k < 4; k++) begin
            b = 4'($urandom_range(0, 15));
            drive($sformatf("rnd%0d_in", k),  8'h20, b, 4'(3 * k + 1), exp_led);
            drive($sformatf("rnd%0d_mov", k), 8'h40, 4'($urandom_range(0, 15)), 4'(3 * k + 2), exp_led);
            exp_led = b;
            drive($sformatf("rnd%0d_out", k), 8'h90, 4'($urandom_range(0, 15)), 4'(3 * k + 3), exp_led);
        end

        // Counting program from memory, then reset while OUT B is pending
        mem[0] = 8'hB1; mem[1] = 8'h01; mem[2] = 8'h33; mem[3] = 8'h00;
        mem[4] = 8'h53; mem[5] = 8'h91; mem[6] = 8'hF4;
        cnt_adr = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h4, 4'h5, 4'h6, 4'h4, 4'h5};
        cnt_led = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h3, 4'h3, 4'h3, 4'h6, 4'h6, 4'h6};
        reset_dut();
        use_mem = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step($sformatf("count%0d", i), cnt_adr[i], cnt_led[i]);
        end
        reset = 1'b1;
        step("count_midrun_reset", 4'h0, 4'h0);
        reset = 1'b0;
        step("count_restart", 4'h1, 4'h1);
        use_mem = 1'b0;

        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
